// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder used as the arithmetic core of the serial adder.
module serial_add_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: operands are shifted LSB-first through a single full-add
// cell over WIDTH cycles; the registered sum and carry are published on the DONE cycle.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;

    serial_add_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_next = {cell_s, res_sr[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: every datapath register, shift registers included, is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= cell_c;
                    cnt    <= cnt + CW'(1);
                    // Publish on the edge that enters DONE so sum/cout are valid with done.
                    if (last_bit) begin
                        sum  <= res_next;
                        cout <= cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL request an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be operand A, captured on the accepted start edge.
REQ-006 b  input  WIDTH  SHALL be operand B, captured on the accepted start edge.
REQ-007 busy  output  1  SHALL be high while the serial add is in progress (RUN state).
REQ-008 done  output  1  SHALL be a one-cycle pulse marking sum/cout valid.
REQ-009 sum  output  WIDTH  SHALL be the registered result A+B mod 2^WIDTH.
REQ-010 cout  output  1  SHALL be the registered carry-out of A+B.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; one state register plus a next-state combinational block.
REQ-012 IDLE with start=1 SHALL latch a and b into two shift registers, clear the carry flop and bit counter, and go to RUN.
REQ-013 IDLE with start=0 SHALL remain in IDLE with no register changes.
REQ-014 RUN SHALL present bit 0 of each shift register plus the carry to the adder cell each cycle, then shift both operands right by one.
REQ-015 RUN SHALL shift the cell's sum bit into the MSB of a result shift register, so after WIDTH cycles bit i holds sum bit i.
REQ-016 RUN SHALL update the carry flop from the cell's carry-out each cycle.
REQ-017 RUN SHALL last exactly WIDTH cycles, counted by a counter of $clog2(WIDTH+1) bits, then go to DONE.
REQ-018 On entry to DONE, sum SHALL load the result register and cout the final carry; done=1 for exactly that cycle; the next state is IDLE.
REQ-019 Latency: start accepted at edge N SHALL give busy high for cycles N+1..N+WIDTH and done high in cycle N+WIDTH+1.
REQ-020 start SHALL be ignored in RUN and DONE; operand changes during RUN SHALL NOT affect the result.
REQ-021 If start is held high continuously, a new operation SHALL be accepted on the first IDLE cycle after DONE (period WIDTH+2 cycles).
REQ-022 sum and cout SHALL hold their last values until the next DONE; they SHALL NOT change during RUN.
REQ-023 The arithmetic SHALL be unsigned; the carry beyond WIDTH SHALL appear only on cout, never as a wrap error.

Reset
REQ-024 rst=1 SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and clear the shift registers, regardless of state.
REQ-025 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the next start after reset SHALL behave normally.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state encoding constants (IDLE=0, RUN=1, DONE=2) and the default WIDTH.
REQ-028 The per-bit full-add SHALL be a sub-module serial_add_cell with inputs x, y, cin and outputs s, cout (combinational), instantiated once.
REQ-029 The controller SHALL own all sequential state: carry flop, counter, shift registers, FSM.

Verification (WIDTH=8)
REQ-030 a=0x00, b=0x00, start pulse -> done after 9 cycles, sum=0x00, cout=0.
REQ-031 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-032 a=0xA5, b=0x5A; drive a=0x00 during RUN and pulse start in RUN -> sum=0xFF, cout=0, only one done pulse.
REQ-033 start held high for 30 cycles with a=0x03, b=0x04 -> done pulses every 10 cycles, each with sum=0x07, cout=0.
REQ-034 rst=1 at the 4th RUN cycle of 0x80+0x80 -> busy=0, no done, sum=0, cout=0; a new 0x80+0x80 then gives sum=0x00, cout=1.
REQ-035 Bench SHALL compare every done against a reference {cout,sum}=a+b model and check busy is never high with done.
